// File: rtl/msk_sbox_layer_ctrl.sv
// msk_sbox_layer_ctrl: sequences one sbox layer over NCOL column groups
// through a shared, non-stalling masked sbox pipeline of fixed latency LAT.
// An issue happens only when fresh masking randomness is offered, so the
// randomness is never reused; write-backs mirror the issue pattern LAT
// cycles later.
//
// Handshake: rnd_valid/rnd_ready follow strict valid/ready semantics.
// rnd_ready is combinational from rnd_valid and the FSM state; a unit of
// randomness is consumed in exactly the cycles where rnd_valid && rnd_ready.
// rnd_ready never depends on anything downstream because the sbox pipeline
// cannot stall.
module msk_sbox_layer_ctrl #(
    parameter int d    = 4,
    parameter int NCOL = 8,
    parameter int LAT  = 2,
    localparam int CW  = $clog2(NCOL)
) (
    input  logic          clk,
    input  logic          syn_rst,
    input  logic          start,
    input  logic          inverse,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    output logic          sb_issue,
    output logic [CW-1:0] col_sel,
    output logic          inv_en,
    output logic          wb_en,
    output logic [CW-1:0] wb_sel,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

    // Parameter sanity: the controller only supports these ranges.
    if (NCOL < 2 || NCOL > 32) begin : g_bad_ncol
        $error("msk_sbox_layer_ctrl: NCOL must be in 2..32");
    end
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("msk_sbox_layer_ctrl: LAT must be in 1..4");
    end
    if (d < 2) begin : g_bad_d
        $error("msk_sbox_layer_ctrl: a masked datapath needs at least 2 shares");
    end

    state_t          state_q;
    logic [CW-1:0]   issue_cnt_q;
    logic            mode_q;
    logic            busy_q;
    logic            done_q;
    logic [LAT-1:0]  vld_q;
    logic [CW-1:0]   idx_q [LAT];
    logic            issue;
    logic            last_wb_next;

    // An issue needs RUN and fresh randomness; reset suppresses everything.
    assign issue = (state_q == S_RUN) && rnd_valid && !syn_rst;

    // True when the write-back of column NCOL-1 will appear next cycle, so the
    // DONE state lines up with that final write-back.
    if (LAT == 1) begin : g_last_lat1
        assign last_wb_next = issue && (issue_cnt_q == LAST);
    end else begin : g_last_latn
        assign last_wb_next = vld_q[LAT-2] && (idx_q[LAT-2] == LAST);
    end

    // Layer FSM with registered status outputs and the issue counter.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        issue_cnt_q <= '0;
                        mode_q      <= inverse;
                        busy_q      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (issue_cnt_q == LAST) begin
                            // Counter holds at NCOL-1; no more issues this layer.
                            if (last_wb_next) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            issue_cnt_q <= issue_cnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_wb_next) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    issue_cnt_q <= '0;
                    mode_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sbox pipeline tracker: shifts every cycle since the pipeline never stalls.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            idx_q[0] <= issue ? issue_cnt_q : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign sb_issue  = issue;
    assign rnd_ready = issue;
    assign col_sel   = issue ? issue_cnt_q : '0;
    assign wb_en     = vld_q[LAT-1] && !syn_rst;
    assign wb_sel    = wb_en ? idx_q[LAT-1] : '0;
    assign busy      = busy_q && !syn_rst;
    assign done      = done_q && !syn_rst;
    assign inv_en    = mode_q && busy_q && !syn_rst;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_msk_sbox_layer_ctrl.sv
// Bench for msk_sbox_layer_ctrl: a directed vector table for the nominal
// layer, hand-written sequences for the corner cases, then random stimulus,
// all checked every cycle against a time-based reference model.
module tb_msk_sbox_layer_ctrl;
  localparam int NCOL = 8;
  localparam int LAT  = 2;
  localparam int CW   = $clog2(NCOL);
  localparam int OW   = 2 * CW + 6;

  logic          clk = 1'b0;
  logic          syn_rst, start, inverse, rnd_valid;
  logic          rnd_ready, sb_issue, inv_en, wb_en, busy, done;
  logic [CW-1:0] col_sel, wb_sel;
  logic [1:0]    dbg_state;

  msk_sbox_layer_ctrl #(.d(4), .NCOL(NCOL), .LAT(LAT)) dut (
    .clk(clk), .syn_rst(syn_rst), .start(start), .inverse(inverse),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .sb_issue(sb_issue),
    .col_sel(col_sel), .inv_en(inv_en), .wb_en(wb_en), .wb_sel(wb_sel),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    bit            st, inv, rv, rst;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tab[12];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model: time-stamped write-back scoreboard
  bit            m_busy = 0;
  bit            m_mode = 0;
  int            m_next = 0;
  int            m_done_cyc = -1;
  int            due_q[$];
  logic [CW-1:0] exp_q[$];
  int            c_iss = 0, c_rdy = 0, c_wb = 0;

  function automatic logic [OW-1:0] pack(bit iss, bit rdy, logic [CW-1:0] c, bit inv,
                                         bit wb, logic [CW-1:0] ws, bit b, bit dn);
    return {iss, rdy, c, inv, wb, ws, b, dn};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b (iss,rdy,col,inv,wb,wbsel,busy,done)",
               name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // one clock cycle: drive, compare at negedge, advance model, step
  task automatic cycle(input bit st, input bit inv, input bit rv, input bit rst,
                       input bit use_tab, input logic [OW-1:0] tab_exp);
    bit            e_iss, e_wb, e_busy, e_done, e_inv;
    logic [CW-1:0] e_col, e_ws;
    logic [OW-1:0] act;
    start = st; inverse = inv; rnd_valid = rv; syn_rst = rst;
    @(negedge clk);
    e_iss  = !rst && m_busy && (m_next < NCOL) && rv;
    e_col  = e_iss ? CW'(m_next) : '0;
    e_wb   = !rst && (due_q.size() > 0) && (due_q[0] == cyc);
    e_ws   = e_wb ? exp_q[0] : '0;
    e_busy = !rst && m_busy;
    e_done = !rst && m_busy && (m_done_cyc == cyc);
    e_inv  = !rst && m_busy && m_mode;
    act = pack(sb_issue, rnd_ready, col_sel, inv_en, wb_en, wb_sel, busy, done);
    check("model", act, pack(e_iss, e_iss, e_col, e_inv, e_wb, e_ws, e_busy, e_done));
    if (use_tab) check("table", act, tab_exp);
    c_iss += int'(sb_issue);
    c_rdy += int'(rnd_ready);
    c_wb  += int'(wb_en);
    if (e_done) begin
      check_int("layer_issues", c_iss, NCOL);
      check_int("layer_rnd_ready", c_rdy, NCOL);
      check_int("layer_writebacks", c_wb, NCOL);
    end
    if (rst) begin
      m_busy = 0; m_mode = 0; m_next = 0; m_done_cyc = -1;
      due_q.delete(); exp_q.delete();
      c_iss = 0; c_rdy = 0; c_wb = 0;
    end else begin
      if (e_wb) begin
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (e_iss) begin
        due_q.push_back(cyc + LAT);
        exp_q.push_back(CW'(m_next));
        if (m_next == NCOL - 1) m_done_cyc = cyc + LAT;
        m_next++;
      end
      if (e_done) begin
        m_busy = 0;
      end else if (!m_busy && st) begin
        m_busy = 1; m_mode = inv; m_next = 0; m_done_cyc = -1;
        c_iss = 0; c_rdy = 0; c_wb = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input bit st, input bit inv, input bit rv, input bit rst);
    cycle(st, inv, rv, rst, 1'b0, '0);
  endtask

  initial begin
    // nominal layer: start at row 0, issues rows 1..8, wb rows 3..10, done row 10
    for (int k = 0; k < 12; k++) begin
      bit iss, wb, b, dn;
      logic [CW-1:0] c, ws;
      iss = (k >= 1 && k <= NCOL);
      c   = iss ? CW'(k - 1) : '0;
      wb  = (k >= 1 + LAT && k <= NCOL + LAT);
      ws  = wb ? CW'(k - 1 - LAT) : '0;
      b   = (k >= 1 && k <= NCOL + LAT);
      dn  = (k == NCOL + LAT);
      tab[k] = '{st: (k == 0), inv: 1'b0, rv: 1'b1, rst: 1'b0,
                 exp: pack(iss, iss, c, 1'b0, wb, ws, b, dn)};
    end

    @(posedge clk);
    #1;
    run(0, 0, 1, 1);
    run(1, 1, 1, 1);   // reset dominates start
    run(0, 0, 1, 0);
    run(0, 0, 1, 0);

    for (int k = 0; k < 12; k++) cycle(tab[k].st, tab[k].inv, tab[k].rv, tab[k].rst, 1'b1, tab[k].exp);
    run(0, 0, 0, 0);

    // inverse layer with inverse toggling mid-layer
    run(1, 1, 1, 0);
    for (int k = 1; k < 14; k++) run(0, k[0], 1, 0);

    // randomness gap in run cycles 3..5
    run(1, 0, 1, 0);
    for (int k = 1; k < 16; k++) run(0, 0, !(k >= 3 && k <= 5), 0);

    // start held high the whole layer, including the DONE cycle
    run(1, 0, 1, 0);
    for (int k = 1; k < 11; k++) run(1, 1, 1, 0);
    for (int k = 0; k < 14; k++) run(0, 0, 1, 0);

    // reset after four issues, then a clean full layer
    run(1, 1, 1, 0);
    for (int k = 0; k < 4; k++) run(0, 0, 1, 0);
    run(0, 0, 1, 1);
    for (int k = 0; k < 5; k++) run(0, 0, 1, 0);
    run(1, 0, 1, 0);
    for (int k = 0; k < 13; k++) run(0, 0, 1, 0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      run($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) < 7, $urandom_range(0, 149) == 0);
    end
    for (int k = 0; k < 30; k++) run(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/msk_sbox_layer_ctrl.md
MSK_SBOX_LAYER_CTRL -- requirements
Module: MSKsbox_layer_ctrl

Interface
REQ-001 Parameter d, default 4: number of shares of the masked datapath; no effect on controller logic except pass-through width checks.
REQ-002 Parameter NCOL, default 8: number of column groups per sbox layer, range 2..32.
REQ-003 Parameter LAT, default 2: fixed latency in cycles of the shared masked sbox pipeline, range 1..4.
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port syn_rst  in  1  reset, synchronous, active-high.
REQ-006 Port start  in  1  request one full sbox layer; sampled only in IDLE.
REQ-007 Port inverse  in  1  layer mode, 1 = decryption (inverse sbox), sampled with start.
REQ-008 Port rnd_valid  in  1  fresh masking randomness available for one sbox issue.
REQ-009 Port rnd_ready  out  1  randomness consumed this cycle; equals sb_issue.
REQ-010 Port sb_issue  out  1  present column group col_sel to sbox pipeline this cycle.
REQ-011 Port col_sel  out  $clog2(NCOL)  column group index being issued.
REQ-012 Port inv_en  out  1  enables pre/post inverse linear layers around the sbox; held constant for the whole layer.
REQ-013 Port wb_en  out  1  sbox output valid, write back to state.
REQ-014 Port wb_sel  out  $clog2(NCOL)  column group index being written back.
REQ-015 Port busy  out  1  high from start acceptance until done.
REQ-016 Port done  out  1  single-cycle pulse when last write-back has occurred.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE; encoding free.
REQ-018 IDLE -> RUN on start=1; inverse latched into mode register; issue counter and retire counter cleared.
REQ-019 start while not IDLE is ignored; inverse changes while busy do not affect inv_en.
REQ-020 In RUN, sb_issue = rnd_valid; no issue without randomness (masking security, never reuse randomness).
REQ-021 On each issue: col_sel = issue counter value, counter increments by 1.
REQ-022 RUN -> DRAIN on the cycle issuing column NCOL-1.
REQ-023 Pipeline tracking: LAT-deep shift register of (valid, index); entry shifts every cycle regardless of rnd_valid (sbox pipeline never stalls).
REQ-024 wb_en asserts exactly LAT cycles after the corresponding sb_issue; wb_sel equals the col_sel issued then.
REQ-025 Gaps in rnd_valid produce identical gaps in wb_en; write-back order equals issue order.
REQ-026 DRAIN -> DONE on the cycle the write-back of column NCOL-1 occurs.
REQ-027 DONE lasts one cycle: done=1, busy=1, then -> IDLE; a start in DONE is ignored.
REQ-028 inv_en = latched mode while busy; 0 in IDLE.
REQ-029 col_sel, wb_sel = 0 when respective enable is low.
REQ-030 Minimum layer duration with rnd_valid constantly high: NCOL+LAT+1 cycles from start to IDLE (done in cycle NCOL+LAT after start).
REQ-031 Counters never wrap within a layer; issue counter saturates at NCOL-1 transition, no issue in DRAIN/DONE.

Reset
REQ-032 syn_rst=1 at any edge: state -> IDLE, counters, mode and pipeline valid bits cleared.
REQ-033 During and the cycle after reset: sb_issue, rnd_ready, wb_en, busy, done, inv_en all 0; col_sel, wb_sel 0.
REQ-034 Reset mid-layer aborts: no pending wb_en emitted afterwards, no done pulse.
REQ-035 syn_rst dominates start in the same cycle.

Verification
REQ-036 NCOL=8, LAT=2, start, inverse=0, rnd_valid=1 -> issues col 0..7 cycles 1..8, wb 0..7 cycles 3..10, done at cycle 10, inv_en=0 throughout.
REQ-037 inverse=1 start, then inverse toggled mid-layer -> inv_en=1 constant until done, 0 after.
REQ-038 rnd_valid low for cycles 3..5 of RUN -> no issue/rnd_ready in those cycles, wb_en gap of 3 cycles shifted by LAT, done delayed by 3.
REQ-039 start pulsed during RUN and during DONE -> ignored; exactly one done, next start accepted only from IDLE.
REQ-040 syn_rst asserted after 4 issues -> all outputs 0 next cycle, no further wb_en, no done; subsequent start runs full layer normally.
REQ-041 Check for all cases: count(rnd_ready)=count(sb_issue)=count(wb_en)=NCOL per completed layer.
